// File: rtl/uart_rx_loader_if.sv
// Image-memory write port driven by uart_rx_loader.
// The loader drives the master side and the image memory consumes the slave side.
interface uart_rx_loader_if #(
    parameter int W    = 8,
    parameter int LOGD = 14
);
    logic            wr_en;
    logic [LOGD-1:0] wr_addr;
    logic [W-1:0]    wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_rx_loader.sv
// UART receiver that streams D image bytes into memory and then raises load_done.
// Frame format is 8N1 by default; defining RX_PARITY_EN switches to 8E1 and adds a sticky parity_err output.
module uart_rx_loader #(
    parameter int W            = 8,
    parameter int D            = 16384,
    parameter int LOGD         = 14,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    uart_rx_loader_if.master     wr,
    output logic                 load_done,
    output logic                 frame_err,
`ifdef RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic [LOGD:0]        byte_cnt
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(W - 1);
    localparam logic [LOGD:0]  D_LAST   = (LOGD + 1)'(D - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WRITE,
        S_WAITIDLE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic            wr_en_q, wr_en_d;
    logic [LOGD-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0]    wr_data_q, wr_data_d;
    logic [LOGD:0]   byte_cnt_q, byte_cnt_d;
    logic            load_done_q, load_done_d;
    logic            frame_err_q, frame_err_d;
`ifdef RX_PARITY_EN
    logic            parity_err_q, parity_err_d;
    logic            parity_bad_q, parity_bad_d;
`endif
    logic            rx_fall;

    // rx_prev_q tracks rx_s_q in every state so a start edge landing during WRITE is still seen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RxD;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            byte_cnt_q   <= '0;
            load_done_q  <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err_q <= 1'b0;
            parity_bad_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            byte_cnt_q   <= byte_cnt_d;
            load_done_q  <= load_done_d;
            frame_err_q  <= frame_err_d;
`ifdef RX_PARITY_EN
            parity_err_q <= parity_err_d;
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q + CW'(1);
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        byte_cnt_d   = byte_cnt_q;
        load_done_d  = load_done_q;
        frame_err_d  = frame_err_q;
`ifdef RX_PARITY_EN
        parity_err_d = parity_err_q;
        parity_bad_d = parity_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d       = '0;
                    shreg_d[idx_q]  = rx_s_q;
                    idx_d           = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d    = '0;
                    parity_bad_d = (rx_s_q != ^shreg_q);
                    parity_err_d = parity_err_q | (rx_s_q != ^shreg_q);
                    state_d      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d = '0;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAITIDLE;
`ifdef RX_PARITY_EN
                    end else if (parity_bad_q) begin
                        state_d     = S_IDLE;
`endif
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = byte_cnt_q[LOGD-1:0];
                        wr_data_d = shreg_q;
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                byte_cnt_d = byte_cnt_q + (LOGD + 1)'(1);
                if (byte_cnt_q == D_LAST) begin
                    load_done_d = 1'b1;
                    state_d     = S_DONE;
                end else if (rx_fall) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAITIDLE: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wr.wr_en   = wr_en_q;
    assign wr.wr_addr = wr_addr_q;
    assign wr.wr_data = wr_data_q;
    assign load_done  = load_done_q;
    assign frame_err  = frame_err_q;
    assign byte_cnt   = byte_cnt_q;
`ifdef RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif
endmodule
